conv_ctrl_tiled: RTL and testbench
==================================

Name: conv_ctrl_tiled

Overview:
Parametrised successor to the convolution input controller. It latches one im2col kernel window (all input channels × KERNEL_DIM²) and streams it row by row into V_CIM_TILES vertically stacked crossbar tiles. It masks and zero-fills the unused rows of the last tile, then hands off to the CIM with a start/busy handshake. It also counts windows per frame and flags frame completion.

Parameters:
DATATYPE_SIZE, 8, bit width of one activation element
INPUT_CHANNELS, 5, input feature-map channels per window
KERNEL_DIM, 3, kernel height = width
XBAR_SIZE, 256, rows per crossbar tile
NUM_WINDOWS, 16, windows per frame (≥1)
(derived localparams) INPUT_SIZE = INPUT_CHANNELS*KERNEL_DIM**2; V_CIM_TILES = ceil(INPUT_SIZE/XBAR_SIZE); COUNT_LIMIT = (V_CIM_TILES>1) ? XBAR_SIZE : INPUT_SIZE

Ports:
clk  in  1  clock; single clock domain, rising edge
rst  in  1  reset; synchronous, active-high
i_start  in  1  request to load the window currently on i_data
i_data  in  DATATYPE_SIZE × INPUT_SIZE (unpacked)  window elements; index = ch*KERNEL_DIM**2 + k
i_cim_busy  in  1  CIM tiles busy computing / not ready for writes
i_func_busy  in  1  downstream function unit busy
o_busy  out  1  controller owns a window
o_cim_we  out  1  row write strobe, common to all tiles
o_tile_we  out  V_CIM_TILES  per-tile row write enable (masked copy of o_cim_we)
o_cim_addr  out  clog2(XBAR_SIZE)  row address within every tile
o_data  out  DATATYPE_SIZE × V_CIM_TILES (unpacked)  row data, one element per tile
o_cim_start  out  1  compute request to CIM
o_window_idx  out  clog2(NUM_WINDOWS) (min 1)  index of current window in frame
o_frame_done  out  1  one-cycle pulse after last window of frame handed off

Behaviour:
- Reset: state IDLE, addr=0, window_idx=0, buffer contents don't-care. All outputs are 0 (o_data=0), effective at the next rising edge. Reset mid-operation aborts immediately; there is no partial completion and no o_frame_done.
- States: IDLE, WAIT_CIM, LOAD, WAIT_FUNC, HANDOFF.
- IDLE: o_busy=0. On i_start=1, capture all of i_data into an internal buffer at that edge. Go to LOAD if i_cim_busy=0, else WAIT_CIM. i_data is don't-care afterwards.
- WAIT_CIM: o_busy=1, we=0. Go to LOAD when i_cim_busy=0.
- LOAD: o_busy=1, o_cim_we=1, o_cim_addr=addr.
  - Tile t uses row r = t*XBAR_SIZE + addr.
  - o_data[t] = buf[r] and o_tile_we[t]=1 if r < INPUT_SIZE; otherwise o_data[t]=0 and o_tile_we[t]=0.
  - addr increments each cycle. At addr==COUNT_LIMIT-1: addr→0, go to WAIT_FUNC.
  - i_cim_busy is ignored in LOAD.
- WAIT_FUNC: o_busy=1, we=0. Go to HANDOFF when i_func_busy=0.
- HANDOFF: o_busy=1, o_cim_start=1 (level), held until i_cim_busy=1 is sampled. On that edge:
  - drop o_cim_start and go to IDLE;
  - window_idx++;
  - if window_idx was NUM_WINDOWS-1, wrap to 0 and pulse o_frame_done for the following cycle.
- Latency: i_start at edge 0 with CIM idle gives first write (addr 0) in cycle 1 and last write in cycle COUNT_LIMIT. WAIT_FUNC is entered at cycle COUNT_LIMIT+1. Minimum start→o_cim_start is COUNT_LIMIT+2 cycles.
- i_start outside IDLE is ignored (not queued). i_start in the same cycle as rst is ignored.
- New i_start is accepted the cycle after the return to IDLE, so back-to-back windows are possible.
- Outputs are registered or decoded from registered state only; there is no combinational path from i_start to o_cim_we.
- Address width covers XBAR_SIZE-1; no wrap beyond COUNT_LIMIT.

Test Plan:
- Defaults (INPUT_SIZE=45, V=1), i_data[n]=n+1, i_start with CIM/func idle → o_cim_we high exactly 45 cycles, addr 0..44, o_data[0]=1..45, o_cim_start at cycle 47.
- XBAR_SIZE=16 (V=3, COUNT_LIMIT=16), i_data[n]=n → 16 writes. Tile2 enabled only for addr 0..12 (data 32..44); addr 13..15 give o_tile_we[2]=0 and o_data[2]=0. Tiles 0/1 are always enabled.
- i_cim_busy=1 at start for 5 cycles → stays in WAIT_CIM with o_busy=1, no writes; first write the cycle after busy drops. Changing i_data after start doesn't alter the written values.
- i_func_busy=1 for 10 cycles after the last write → no o_cim_start until it drops. o_cim_start then holds until i_cim_busy rises, then o_busy=0 next cycle.
- NUM_WINDOWS=3, four back-to-back windows → window_idx 0,1,2,0. o_frame_done pulses once, after the third handoff.
- rst asserted at addr 20 of LOAD → next cycle all outputs 0, state IDLE, window_idx 0. A subsequent i_start restarts from addr 0.

Source files
------------

// File: rtl/conv_ctrl_tiled.sv
// conv_ctrl_tiled: latches an im2col window and streams it row-wise into stacked CIM tiles
module conv_ctrl_tiled #(
  parameter int DATATYPE_SIZE = 8,
  parameter int INPUT_CHANNELS = 5,
  parameter int KERNEL_DIM = 3,
  parameter int XBAR_SIZE = 256,
  parameter int NUM_WINDOWS = 16,
  localparam int INPUT_SIZE = INPUT_CHANNELS * KERNEL_DIM * KERNEL_DIM,
  localparam int V_CIM_TILES = (INPUT_SIZE + XBAR_SIZE - 1) / XBAR_SIZE,
  localparam int COUNT_LIMIT = (V_CIM_TILES > 1) ? XBAR_SIZE : INPUT_SIZE,
  localparam int AW = (XBAR_SIZE > 1) ? $clog2(XBAR_SIZE) : 1,
  localparam int WW = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [DATATYPE_SIZE-1:0] i_data [INPUT_SIZE],
  input  logic                     i_cim_busy,
  input  logic                     i_func_busy,
  output logic                     o_busy,
  output logic                     o_cim_we,
  output logic [V_CIM_TILES-1:0]   o_tile_we,
  output logic [AW-1:0]            o_cim_addr,
  output logic [DATATYPE_SIZE-1:0] o_data [V_CIM_TILES],
  output logic                     o_cim_start,
  output logic [WW-1:0]            o_window_idx,
  output logic                     o_frame_done
);
  localparam int RW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  typedef enum logic [2:0] {IDLE, WAIT_CIM, LOAD, WAIT_FUNC, HANDOFF} state_t;
  state_t state_q, state_d;
  logic [DATATYPE_SIZE-1:0] data_q [INPUT_SIZE];
  logic [AW-1:0] addr_q;
  logic [WW-1:0] idx_q;
  logic done_q;
  logic addr_last, hand, last;
  assign addr_last = addr_q == AW'(COUNT_LIMIT - 1);
  assign hand = state_q == HANDOFF && i_cim_busy;
  assign last = idx_q == WW'(NUM_WINDOWS - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (i_start) state_d = i_cim_busy ? WAIT_CIM : LOAD;
      WAIT_CIM:  if (!i_cim_busy) state_d = LOAD;
      LOAD:      if (addr_last) state_d = WAIT_FUNC;
      WAIT_FUNC: if (!i_func_busy) state_d = HANDOFF;
      HANDOFF:   if (i_cim_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      idx_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= hand && last;
      if (state_q == LOAD) addr_q <= addr_last ? '0 : addr_q + 1'b1;
      if (hand) idx_q <= last ? '0 : idx_q + 1'b1;
    end
  end
  // The window buffer needs no reset; it is always written before it is read.
  always_ff @(posedge clk)
    if (!rst && state_q == IDLE && i_start) data_q <= i_data;
  assign o_busy = state_q != IDLE;
  assign o_cim_we = state_q == LOAD;
  assign o_cim_addr = addr_q;
  assign o_cim_start = state_q == HANDOFF;
  assign o_window_idx = idx_q;
  assign o_frame_done = done_q;
  for (genvar t = 0; t < V_CIM_TILES; t++) begin : g_tile
    localparam int BASE = t * XBAR_SIZE;
    logic [RW-1:0] r;
    assign r = RW'(BASE + int'(addr_q));
    assign o_tile_we[t] = o_cim_we && (BASE + int'(addr_q)) < INPUT_SIZE;
    assign o_data[t] = o_tile_we[t] ? data_q[r] : '0;
  end
endmodule

// File: tb/tb_conv_ctrl_tiled.sv
// tb_conv_ctrl_tiled: directed checks of a default instance and a 3-tile, 3-window instance
module tb_conv_ctrl_tiled;
  localparam int D = 8;
  localparam int N = 45;
  logic clk = 0;
  logic rst;
  always #5 clk = ~clk;

  logic a_start, a_cb, a_fb;
  logic [D-1:0] a_data [N];
  logic a_busy, a_we, a_cs, a_fd;
  logic [0:0] a_twe;
  logic [7:0] a_addr;
  logic [D-1:0] a_odata [1];
  logic [3:0] a_idx;

  logic b_start, b_cb, b_fb;
  logic [D-1:0] b_data [N];
  logic b_busy, b_we, b_cs, b_fd;
  logic [2:0] b_twe;
  logic [3:0] b_addr;
  logic [D-1:0] b_odata [3];
  logic [1:0] b_idx;

  int n_chk = 0;
  int n_pass = 0;
  int a_exp [N];

  conv_ctrl_tiled u_a (
    .clk(clk), .rst(rst), .i_start(a_start), .i_data(a_data), .i_cim_busy(a_cb),
    .i_func_busy(a_fb), .o_busy(a_busy), .o_cim_we(a_we), .o_tile_we(a_twe),
    .o_cim_addr(a_addr), .o_data(a_odata), .o_cim_start(a_cs),
    .o_window_idx(a_idx), .o_frame_done(a_fd)
  );

  conv_ctrl_tiled #(.XBAR_SIZE(16), .NUM_WINDOWS(3)) u_b (
    .clk(clk), .rst(rst), .i_start(b_start), .i_data(b_data), .i_cim_busy(b_cb),
    .i_func_busy(b_fb), .o_busy(b_busy), .o_cim_we(b_we), .o_tile_we(b_twe),
    .o_cim_addr(b_addr), .o_data(b_odata), .o_cim_start(b_cs),
    .o_window_idx(b_idx), .o_frame_done(b_fd)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic a_stream(input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("a_we[%0d]", i), int'(a_we), 1);
      check($sformatf("a_twe[%0d]", i), int'(a_twe), 1);
      check($sformatf("a_addr[%0d]", i), int'(a_addr), i);
      check($sformatf("a_data[%0d]", i), int'(a_odata[0]), a_exp[i]);
      check($sformatf("a_busy[%0d]", i), int'(a_busy), 1);
      tick();
    end
  endtask

  task automatic a_zero(input string tag);
    check({tag, "_busy"}, int'(a_busy), 0);
    check({tag, "_we"}, int'(a_we), 0);
    check({tag, "_twe"}, int'(a_twe), 0);
    check({tag, "_addr"}, int'(a_addr), 0);
    check({tag, "_data"}, int'(a_odata[0]), 0);
    check({tag, "_cs"}, int'(a_cs), 0);
    check({tag, "_idx"}, int'(a_idx), 0);
    check({tag, "_fd"}, int'(a_fd), 0);
  endtask

  initial begin
    rst = 1;
    {a_start, a_cb, a_fb, b_start, b_cb, b_fb} = '0;
    for (int n = 0; n < N; n++) begin
      a_data[n] = D'(n + 1);
      a_exp[n] = n + 1;
      b_data[n] = D'(n);
    end
    tick();
    tick();
    a_zero("rst");
    check("rst_b_busy", int'(b_busy), 0);
    check("rst_b_idx", int'(b_idx), 0);
    rst = 0;

    // basic window: 45 writes, start at cycle 47; data changed after capture
    a_start = 1;
    tick();
    a_start = 0;
    for (int n = 0; n < N; n++) a_data[n] = 8'hFF;
    a_stream(N);
    check("t1_wf_we", int'(a_we), 0);
    check("t1_wf_busy", int'(a_busy), 1);
    check("t1_wf_cs", int'(a_cs), 0);
    tick();
    check("t1_cs", int'(a_cs), 1);
    a_cb = 1;
    tick();
    a_cb = 0;
    check("t1_idle_busy", int'(a_busy), 0);
    check("t1_idle_cs", int'(a_cs), 0);
    check("t1_idx", int'(a_idx), 1);

    // CIM busy at start, then function unit busy after the last write
    for (int n = 0; n < N; n++) begin
      a_data[n] = D'(2 * n);
      a_exp[n] = 2 * n;
    end
    a_start = 1;
    a_cb = 1;
    tick();
    a_start = 0;
    for (int n = 0; n < N; n++) a_data[n] = '0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_wc_busy%0d", k), int'(a_busy), 1);
      check($sformatf("t2_wc_we%0d", k), int'(a_we), 0);
      tick();
    end
    check("t2_wc_we4", int'(a_we), 0);
    a_cb = 0;
    a_fb = 1;
    tick();
    a_stream(N);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t2_fb_cs%0d", k), int'(a_cs), 0);
      check($sformatf("t2_fb_busy%0d", k), int'(a_busy), 1);
      tick();
    end
    a_fb = 0;
    check("t2_fb_cs_drop", int'(a_cs), 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t2_cs_hold%0d", k), int'(a_cs), 1);
      tick();
    end
    a_cb = 1;
    check("t2_cs_last", int'(a_cs), 1);
    tick();
    a_cb = 0;
    check("t2_idle_busy", int'(a_busy), 0);
    check("t2_idle_cs", int'(a_cs), 0);
    check("t2_idx", int'(a_idx), 2);

    // reset in the middle of LOAD, then a clean restart
    for (int n = 0; n < N; n++) begin
      a_data[n] = D'(n + 1);
      a_exp[n] = n + 1;
    end
    a_start = 1;
    tick();
    a_start = 0;
    a_stream(20);
    check("t3_addr20", int'(a_addr), 20);
    rst = 1;
    a_start = 1;
    tick();
    a_zero("t3_rst");
    rst = 0;
    tick();
    a_start = 0;
    a_stream(3);

    // three tiles, three windows per frame, four windows back to back
    for (int w = 0; w < 4; w++) begin
      check($sformatf("b_idx_w%0d", w), int'(b_idx), w % 3);
      b_start = 1;
      tick();
      b_start = 0;
      for (int i = 0; i < 16; i++) begin
        check($sformatf("b_we_w%0d_%0d", w, i), int'(b_we), 1);
        check($sformatf("b_addr_w%0d_%0d", w, i), int'(b_addr), i);
        check($sformatf("b_twe_w%0d_%0d", w, i), int'(b_twe), i < 13 ? 7 : 3);
        check($sformatf("b_d0_w%0d_%0d", w, i), int'(b_odata[0]), i);
        check($sformatf("b_d1_w%0d_%0d", w, i), int'(b_odata[1]), 16 + i);
        check($sformatf("b_d2_w%0d_%0d", w, i), int'(b_odata[2]), i < 13 ? 32 + i : 0);
        tick();
      end
      check($sformatf("b_wf_we_w%0d", w), int'(b_we), 0);
      check($sformatf("b_wf_cs_w%0d", w), int'(b_cs), 0);
      check($sformatf("b_wf_fd_w%0d", w), int'(b_fd), 0);
      tick();
      check($sformatf("b_cs_w%0d", w), int'(b_cs), 1);
      b_cb = 1;
      tick();
      b_cb = 0;
      check($sformatf("b_busy_w%0d", w), int'(b_busy), 0);
      check($sformatf("b_fd_w%0d", w), int'(b_fd), w == 2 ? 1 : 0);
    end
    check("b_idx_end", int'(b_idx), 1);
    tick();
    check("b_fd_after", int'(b_fd), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
